// File: rtl/dma_avmm_burst_responder.sv
// Avalon-MM 256-bit burst slave fronting an on-chip buffer for the AVMM DMA endpoint.
// One outstanding command; read data returns RD_LAT cycles after each issue, fully pipelined.
module dma_avmm_burst_responder #(
  parameter int DATA_W  = 256,
  parameter int ADDR_W  = 16,
  parameter int BURST_W = 5,
  parameter int RD_LAT  = 2
) (
  input  logic                pcie_clk,
  input  logic                pcie_rst,
  input  logic [ADDR_W-1:0]   avs_address,
  input  logic [BURST_W-1:0]  avs_burstcount,
  input  logic [DATA_W/8-1:0] avs_byteenable,
  input  logic                avs_write,
  input  logic [DATA_W-1:0]   avs_writedata,
  input  logic                avs_read,
  output logic                avs_waitrequest,
  output logic [DATA_W-1:0]   avs_readdata,
  output logic                avs_readdatavalid,
  output logic [31:0]         wr_beat_cnt,
  output logic [31:0]         rd_beat_cnt,
  output logic                err_sticky,
  input  logic                err_clr
);

  localparam int IDX_W     = ADDR_W - 5;
  localparam int DEPTH     = 2 ** IDX_W;
  localparam int BE_W      = DATA_W / 8;
  localparam int MAX_BURST = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WR_BURST,
    S_RD_ISSUE
  } state_t;

  state_t              r_state;
  logic                r_wait;
  logic [IDX_W-1:0]    r_idx;
  logic [BURST_W-1:0]  r_left;
  logic [31:0]         r_wr_cnt;
  logic [31:0]         r_rd_cnt;
  logic                r_err;
  logic [DATA_W-1:0]   r_mem     [DEPTH];
  logic [DATA_W-1:0]   r_rd_data [RD_LAT];
  logic [RD_LAT-1:0]   r_rd_vld;

  logic                w_bc_bad;
  logic [BURST_W-1:0]  w_bc_eff;
  logic [IDX_W-1:0]    w_cmd_idx;
  logic                w_accept_slot;
  logic                w_cmd_wr;
  logic                w_cmd_rd;
  logic                w_burst_wr;
  logic                w_rd_issue;
  logic                w_wr_en;
  logic [IDX_W-1:0]    w_wr_idx;
  logic                w_err_set;
  logic                w_addr_unused;

  assign w_addr_unused = ^avs_address[4:0];

  always_comb begin
    w_bc_bad   = (avs_burstcount == '0) || (avs_burstcount > BURST_W'(MAX_BURST));
    w_bc_eff   = w_bc_bad ? BURST_W'(1) : avs_burstcount;
    w_cmd_idx  = avs_address[ADDR_W-1:5];
    // A new command may also be taken on the final issue cycle of a read burst so
    // consecutive read bursts produce an unbroken readdatavalid stream.
    w_accept_slot = !r_wait &&
                    ((r_state == S_IDLE) ||
                     ((r_state == S_RD_ISSUE) && (r_left == BURST_W'(1))));
    w_cmd_wr   = w_accept_slot && avs_write;
    w_cmd_rd   = w_accept_slot && avs_read && !avs_write;
    w_burst_wr = (r_state == S_WR_BURST) && avs_write;
    w_rd_issue = (r_state == S_RD_ISSUE);
    w_wr_en    = w_cmd_wr || w_burst_wr;
    w_wr_idx   = w_cmd_wr ? w_cmd_idx : r_idx;
    w_err_set  = (w_cmd_wr && (avs_read || w_bc_bad)) ||
                 (w_cmd_rd && w_bc_bad) ||
                 ((r_state == S_WR_BURST) && avs_read);
  end

  always_ff @(posedge pcie_clk) begin
    if (w_wr_en) begin
      for (int unsigned b = 0; b < BE_W; b++) begin
        if (avs_byteenable[b]) r_mem[w_wr_idx][8*b +: 8] <= avs_writedata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge pcie_clk or posedge pcie_rst) begin
    if (pcie_rst) begin
      r_state  <= S_IDLE;
      r_wait   <= 1'b1;
      r_idx    <= '0;
      r_left   <= '0;
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
      r_err    <= 1'b0;
      r_rd_vld <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) r_rd_data[i] <= '0;
    end else begin
      if (w_wr_en) r_wr_cnt <= r_wr_cnt + 32'd1;
      if (avs_readdatavalid) r_rd_cnt <= r_rd_cnt + 32'd1;
      if (w_err_set) r_err <= 1'b1;
      else if (err_clr) r_err <= 1'b0;

      r_rd_vld[0]  <= w_rd_issue;
      r_rd_data[0] <= r_mem[r_idx];
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        r_rd_vld[i]  <= r_rd_vld[i-1];
        r_rd_data[i] <= r_rd_data[i-1];
      end

      case (r_state)
        S_IDLE: r_wait <= 1'b0;
        S_WR_BURST: begin
          if (w_burst_wr) begin
            r_idx  <= r_idx + IDX_W'(1);
            r_left <= r_left - BURST_W'(1);
            if (r_left == BURST_W'(1)) r_state <= S_IDLE;
          end
        end
        S_RD_ISSUE: begin
          r_idx  <= r_idx + IDX_W'(1);
          r_left <= r_left - BURST_W'(1);
          if (r_left == BURST_W'(2)) r_wait <= 1'b0;
          if (r_left == BURST_W'(1)) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_cmd_wr) begin
        r_idx   <= w_cmd_idx + IDX_W'(1);
        r_left  <= w_bc_eff - BURST_W'(1);
        r_state <= (w_bc_eff == BURST_W'(1)) ? S_IDLE : S_WR_BURST;
        r_wait  <= 1'b0;
      end else if (w_cmd_rd) begin
        r_idx   <= w_cmd_idx;
        r_left  <= w_bc_eff;
        r_state <= S_RD_ISSUE;
        r_wait  <= (w_bc_eff != BURST_W'(1));
      end
    end
  end

  assign avs_waitrequest   = r_wait;
  assign avs_readdata      = r_rd_data[RD_LAT-1];
  assign avs_readdatavalid = r_rd_vld[RD_LAT-1];
  assign wr_beat_cnt       = r_wr_cnt;
  assign rd_beat_cnt       = r_rd_cnt;
  assign err_sticky        = r_err;

endmodule

// File: tb/tb_dma_avmm_burst_responder.sv
// Randomized bench for dma_avmm_burst_responder against a word-array reference model
// with a timestamped expected-readdata queue.
module tb_dma_avmm_burst_responder;
  localparam int DATA_W  = 256;
  localparam int ADDR_W  = 16;
  localparam int BURST_W = 5;
  localparam int RD_LAT  = 2;
  localparam int DEPTH   = 2048;

  logic               pcie_clk;
  logic               pcie_rst;
  logic [ADDR_W-1:0]  avs_address;
  logic [BURST_W-1:0] avs_burstcount;
  logic [31:0]        avs_byteenable;
  logic               avs_write;
  logic [DATA_W-1:0]  avs_writedata;
  logic               avs_read;
  logic               avs_waitrequest;
  logic [DATA_W-1:0]  avs_readdata;
  logic               avs_readdatavalid;
  logic [31:0]        wr_beat_cnt;
  logic [31:0]        rd_beat_cnt;
  logic               err_sticky;
  logic               err_clr;

  dma_avmm_burst_responder #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BURST_W(BURST_W),
    .RD_LAT (RD_LAT)
  ) u_dut (
    .pcie_clk         (pcie_clk),
    .pcie_rst         (pcie_rst),
    .avs_address      (avs_address),
    .avs_burstcount   (avs_burstcount),
    .avs_byteenable   (avs_byteenable),
    .avs_write        (avs_write),
    .avs_writedata    (avs_writedata),
    .avs_read         (avs_read),
    .avs_waitrequest  (avs_waitrequest),
    .avs_readdata     (avs_readdata),
    .avs_readdatavalid(avs_readdatavalid),
    .wr_beat_cnt      (wr_beat_cnt),
    .rd_beat_cnt      (rd_beat_cnt),
    .err_sticky       (err_sticky),
    .err_clr          (err_clr)
  );

  initial pcie_clk = 1'b0;
  always #5 pcie_clk = ~pcie_clk;

  int unsigned n_err = 0;
  int unsigned n_chk = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    longint       cyc;
    logic [255:0] data;
  } exp_t;

  logic [255:0] m_mem [DEPTH];
  exp_t         q[$];
  exp_t         mon_e;
  int unsigned  m_wr_cnt = 0;
  int unsigned  m_rd_cnt = 0;
  bit           m_err    = 0;
  longint       cyc      = 0;
  int unsigned  g_waits  = 0;
  logic [255:0] wdata [16];

  always @(posedge pcie_clk) cyc <= cyc + 1;

  always @(negedge pcie_clk) begin
    if (!pcie_rst) begin
      if (avs_readdatavalid) begin
        if (q.size() == 0) chk("rdv_unexpected", 1, 0);
        else begin
          mon_e = q.pop_front();
          chk("rd_cycle", cyc, mon_e.cyc);
          chk("rd_data", avs_readdata, mon_e.data);
          m_rd_cnt++;
        end
      end else if (q.size() > 0 && q[0].cyc <= cyc) begin
        chk("rdv_missing", 0, 1);
        mon_e = q.pop_front();
      end
    end
  end

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic int unsigned beats_of(input logic [4:0] bc);
    return (bc == 0 || bc > 16) ? 1 : int'(bc);
  endfunction

  task automatic wait_accept(output longint acc);
    int n = 0;
    @(negedge pcie_clk);
    while (avs_waitrequest && n < 200) begin
      n++;
      @(negedge pcie_clk);
    end
    g_waits += n;
    if (n >= 200) chk("accept_timeout", 1, 0);
    acc = cyc;
    @(posedge pcie_clk);
    #1;
  endtask

  task automatic do_write(input int unsigned word, input logic [4:0] bc, input logic [31:0] be,
                          input int unsigned stall_beat, input int unsigned stall_len,
                          input bit rd_in_stall, input bit clr_in_stall);
    int unsigned nb = beats_of(bc);
    int unsigned idx;
    longint acc;
    if (nb != int'(bc)) m_err = 1;
    for (int unsigned i = 0; i < nb; i++) begin
      if (i > 0 && i == stall_beat) begin
        for (int unsigned s = 0; s < stall_len; s++) begin
          avs_write = 1'b0;
          avs_read  = (s == 0) && rd_in_stall;
          err_clr   = (s == 0) && clr_in_stall;
          if (s == 0 && rd_in_stall) m_err = 1;
          else if (s == 0 && clr_in_stall) m_err = 0;
          @(posedge pcie_clk);
          #1;
          avs_read = 1'b0;
          err_clr  = 1'b0;
        end
      end
      avs_write      = 1'b1;
      avs_address    = ADDR_W'(word << 5) | ADDR_W'($urandom_range(31, 0));
      avs_burstcount = bc;
      avs_byteenable = be;
      avs_writedata  = wdata[i];
      wait_accept(acc);
      idx = (word + i) % DEPTH;
      for (int b = 0; b < 32; b++)
        if (be[b]) m_mem[idx][8*b +: 8] = wdata[i][8*b +: 8];
      m_wr_cnt++;
    end
    avs_write = 1'b0;
  endtask

  task automatic do_read(input int unsigned word, input logic [4:0] bc);
    int unsigned nb = beats_of(bc);
    longint acc;
    exp_t e;
    if (nb != int'(bc)) m_err = 1;
    avs_read       = 1'b1;
    avs_address    = ADDR_W'(word << 5);
    avs_burstcount = bc;
    wait_accept(acc);
    avs_read = 1'b0;
    for (int unsigned k = 0; k < nb; k++) begin
      e.cyc  = acc + 1 + RD_LAT + k;
      e.data = m_mem[(word + k) % DEPTH];
      q.push_back(e);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 300) begin
      n++;
      @(posedge pcie_clk);
    end
    if (q.size() > 0) begin
      chk("drain_timeout", 1, 0);
      q.delete();
    end
    repeat (3) @(posedge pcie_clk);
    #1;
  endtask

  task automatic check_counters(input string tag);
    chk({tag, "_wr_cnt"}, wr_beat_cnt, m_wr_cnt);
    chk({tag, "_rd_cnt"}, rd_beat_cnt, m_rd_cnt);
    chk({tag, "_err"}, err_sticky, m_err);
  endtask

  task automatic apply_reset_checked();
    avs_write = 1'b0;
    avs_read  = 1'b0;
    err_clr   = 1'b0;
    pcie_rst  = 1'b1;
    q.delete();
    m_wr_cnt = 0;
    m_rd_cnt = 0;
    m_err    = 0;
    #1;
    chk("rst_rdv", avs_readdatavalid, 0);
    chk("rst_rdata", avs_readdata, 0);
    chk("rst_waitreq", avs_waitrequest, 1);
    check_counters("rst");
    repeat (2) @(posedge pcie_clk);
    @(negedge pcie_clk);
    pcie_rst = 1'b0;
    @(posedge pcie_clk);
    #1;
    chk("post_rst_waitreq", avs_waitrequest, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned word;
    int unsigned base;
    int unsigned n;
    logic [4:0]  bc;
    avs_address    = '0;
    avs_burstcount = 5'd1;
    avs_byteenable = '1;
    avs_writedata  = '0;
    avs_write      = 1'b0;
    avs_read       = 1'b0;
    err_clr        = 1'b0;
    pcie_rst       = 1'b1;
    #1;
    apply_reset_checked();

    for (int unsigned w = 0; w < DEPTH; w += 16) begin
      for (int i = 0; i < 16; i++) wdata[i] = rnd256();
      do_write(w, 5'd16, '1, 0, 0, 0, 0);
    end
    drain();
    apply_reset_checked();

    // 1: basic burst write then read, data = beat index
    for (int i = 0; i < 16; i++) wdata[i] = 256'(i);
    g_waits = 0;
    do_write(0, 5'd4, '1, 0, 0, 0, 0);
    chk("t1_waitreq_cycles", g_waits, 0);
    repeat (2) @(posedge pcie_clk);
    #1;
    chk("t1_wr_cnt", wr_beat_cnt, m_wr_cnt);
    do_read(0, 5'd4);
    drain();
    check_counters("t1");

    // 2: partial byteenable over an all-ones word
    wdata[0] = '1;
    do_write(5, 5'd1, '1, 0, 0, 0, 0);
    wdata[0] = rnd256();
    do_write(5, 5'd1, 32'h0000_000F, 0, 0, 0, 0);
    do_read(5, 5'd1);
    drain();

    // 3: burst wrapping past the top word
    for (int i = 0; i < 16; i++) wdata[i] = rnd256();
    do_write(2047, 5'd2, '1, 0, 0, 0, 0);
    do_read(2047, 5'd2);
    drain();
    check_counters("t3");

    // 4: mid-burst stall with a read (and a same-cycle clear) during the stall
    for (int i = 0; i < 16; i++) wdata[i] = rnd256();
    do_write(100, 5'd8, '1, 4, 3, 1, 1);
    repeat (2) @(posedge pcie_clk);
    #1;
    check_counters("t4_stall");
    do_read(100, 5'd8);
    drain();
    check_counters("t4_rb");
    err_clr = 1'b1;
    m_err = 0;
    @(posedge pcie_clk);
    #1;
    err_clr = 1'b0;
    chk("t4_err_cleared", err_sticky, 0);

    // 5: back-to-back read bursts
    do_read(200, 5'd16);
    do_read(300, 5'd1);
    drain();
    check_counters("t5");

    // random mixed traffic, no idle gaps between commands
    for (int it = 0; it < 60; it++) begin
      word = $urandom_range(DEPTH - 1, 0);
      n = $urandom_range(9, 0);
      if (n == 0) bc = ($urandom_range(1, 0) == 1) ? 5'd0 : 5'($urandom_range(31, 17));
      else bc = 5'($urandom_range(16, 1));
      if ($urandom_range(1, 0) == 1) begin
        for (int i = 0; i < 16; i++) wdata[i] = rnd256();
        do_write(word, bc, ($urandom_range(3, 0) == 0) ? $urandom : 32'hFFFF_FFFF,
                 $urandom_range(15, 0), $urandom_range(3, 1),
                 $urandom_range(7, 0) == 0, 0);
      end else begin
        do_read(word, bc);
      end
    end
    drain();
    check_counters("rand");

    // 6: reset in the middle of a read burst
    do_read(0, 5'd16);
    base = m_rd_cnt;
    n = 0;
    while (m_rd_cnt < base + 7 && n < 100) begin
      n++;
      @(posedge pcie_clk);
    end
    if (n >= 100) chk("t6_wait_timeout", 1, 0);
    #2;
    pcie_rst = 1'b1;
    q.delete();
    m_wr_cnt = 0;
    m_rd_cnt = 0;
    m_err    = 0;
    #1;
    chk("t6_rdv_flushed", avs_readdatavalid, 0);
    chk("t6_waitreq", avs_waitrequest, 1);
    check_counters("t6_rst");
    repeat (2) @(posedge pcie_clk);
    @(negedge pcie_clk);
    pcie_rst = 1'b0;
    @(posedge pcie_clk);
    #1;
    chk("t6_idle_waitreq", avs_waitrequest, 0);
    chk("t6_rdv_after", avs_readdatavalid, 0);
    do_read(0, 5'd16);
    drain();
    check_counters("t6_rb");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
